// File: rtl/bus_io_timer.sv
// bus_io_timer
//   Memory-mapped I/O responder on the 6502 CPU bus. It provides:
//   - an 8-bit output port
//   - a synchronized 8-bit input port with falling-edge detect on one bit
//   - a 16-bit down-counting timer (one-shot or continuous) with a reload latch
//   - a level IRQ to the CPU
//   Read data is registered: it is valid one cycle after the address, in the
//   same way as the system ROM/RAM.
//
// Ports
//   i_clk      CPU bus clock
//   i_reset    asynchronous, active-high reset
//   i_cs       chip select from the top-level address decoder
//   i_addr     register offset (CPU AB[2:0])
//   i_we       1 = write cycle
//   i_din      write data (CPU DO)
//   o_dout     registered read data (CPU DI)
//   i_port_in  asynchronous external inputs
//   o_port_out output port register
//   o_irq      active-high interrupt request
//
// Register map
//   0 PORT  1 PIN  2 TLO  3 THI  4 CTRL  5 IFR  6,7 read as zero
module bus_io_timer #(
   parameter logic [15:0] TIMER_RESET = 16'hFFFF,
   parameter logic [7:0]  PORT_RESET  = 8'h00,
   parameter int          SYNC_STAGES = 2,
   parameter int          EDGE_BIT    = 0
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_cs,
   input  logic [2:0] i_addr,
   input  logic       i_we,
   input  logic [7:0] i_din,
   output logic [7:0] o_dout,
   input  logic [7:0] i_port_in,
   output logic [7:0] o_port_out,
   output logic       o_irq
);

   localparam logic [2:0] A_PORT = 3'd0;
   localparam logic [2:0] A_PIN  = 3'd1;
   localparam logic [2:0] A_TLO  = 3'd2;
   localparam logic [2:0] A_THI  = 3'd3;
   localparam logic [2:0] A_CTRL = 3'd4;
   localparam logic [2:0] A_IFR  = 3'd5;

   logic [SYNC_STAGES-1:0][7:0] r_sync;
   logic        r_edge_prev;
   logic [15:0] r_latch;
   logic [15:0] r_counter;
   logic        r_running;
   logic [2:0]  r_ctrl;
   logic [1:0]  r_ifr;

   logic       w_wr;
   logic       w_rd;
   logic       w_thi_wr;
   logic       w_uflow;
   logic       w_fall;
   logic [7:0] w_pin;
   logic [1:0] w_ifr_clr;
   logic [1:0] w_ifr_nxt;
   logic [7:0] w_rd_data;

   assign w_wr     = i_cs & i_we;
   assign w_rd     = i_cs & ~i_we;
   assign w_thi_wr = w_wr & (i_addr == A_THI);
   assign w_uflow  = r_running & (r_counter == 16'd0);
   assign w_pin    = r_sync[SYNC_STAGES-1];
   assign w_fall   = r_edge_prev & ~w_pin[EDGE_BIT];

   // A new event on the same edge as a W1C keeps the flag set. A THI write
   // restarts the timer and therefore discards a coincident underflow.
   always_comb begin
      w_ifr_clr    = (w_wr && (i_addr == A_IFR)) ? i_din[1:0] : 2'b00;
      w_ifr_nxt    = r_ifr;
      w_ifr_nxt[0] = w_thi_wr ? 1'b0 : (w_uflow | (r_ifr[0] & ~w_ifr_clr[0]));
      w_ifr_nxt[1] = w_fall | (r_ifr[1] & ~w_ifr_clr[1]);
   end

   always_comb begin
      w_rd_data = 8'h00;
      case (i_addr)
         A_PORT:  w_rd_data = o_port_out;
         A_PIN:   w_rd_data = w_pin;
         A_TLO:   w_rd_data = r_counter[7:0];
         A_THI:   w_rd_data = r_counter[15:8];
         A_CTRL:  w_rd_data = {5'b0, r_ctrl};
         A_IFR:   w_rd_data = {6'b0, r_ifr};
         default: w_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync      <= '0;
         r_edge_prev <= 1'b0;
      end else begin
         r_sync      <= {r_sync[SYNC_STAGES-2:0], i_port_in};
         r_edge_prev <= w_pin[EDGE_BIT];
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_dout     <= 8'h00;
         o_port_out <= PORT_RESET;
         r_ctrl     <= 3'b000;
         r_ifr      <= 2'b00;
      end else begin
         r_ifr <= w_ifr_nxt;
         if (w_rd)
            o_dout <= w_rd_data;
         if (w_wr && (i_addr == A_PORT))
            o_port_out <= i_din;
         if (w_wr && (i_addr == A_CTRL))
            r_ctrl <= i_din[2:0];
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_latch   <= TIMER_RESET;
         r_counter <= 16'd0;
         r_running <= 1'b0;
      end else begin
         if (w_wr && (i_addr == A_TLO))
            r_latch[7:0] <= i_din;
         if (w_thi_wr) begin
            r_latch[15:8] <= i_din;
            r_counter     <= {i_din, r_latch[7:0]};
            r_running     <= 1'b1;
         end else if (w_uflow) begin
            if (r_ctrl[0])
               r_counter <= r_latch;
            else
               r_running <= 1'b0;
         end else if (r_running) begin
            r_counter <= r_counter - 16'd1;
         end
      end
   end

   assign o_irq = (r_ifr[0] & r_ctrl[1]) | (r_ifr[1] & r_ctrl[2]);

endmodule

// File: tb/tb_bus_io_timer.sv
module tb_bus_io_timer;

   logic       clk;
   logic       reset;
   logic       cs;
   logic [2:0] addr;
   logic       we;
   logic [7:0] din;
   logic [7:0] dout;
   logic [7:0] port_in;
   logic [7:0] port_out;
   logic       irq;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] rd;

   bus_io_timer #(
      .TIMER_RESET (16'hFFFF),
      .PORT_RESET  (8'h00),
      .SYNC_STAGES (2),
      .EDGE_BIT    (0)
   ) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_cs       (cs),
      .i_addr     (addr),
      .i_we       (we),
      .i_din      (din),
      .o_dout     (dout),
      .i_port_in  (port_in),
      .o_port_out (port_out),
      .o_irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Both tasks are entered at a falling edge and return at the next one.
   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; addr = a; din = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
      cs = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      cs = 1'b0;
      d = dout;
   endtask

   task automatic test_reset();
      reset = 1'b1; cs = 1'b0; we = 1'b0; addr = 3'd0; din = 8'h00; port_in = 8'h00;
      #1;
      n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
      n_checks++; if (port_out !== 8'h00) begin n_fail++; $display("FAIL reset_port_out: got %h want 00", port_out); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      bus_read(3'd2, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_tlo: got %h want 00", rd); end
      bus_read(3'd3, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_thi: got %h want 00", rd); end
      bus_read(3'd4, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %h want 00", rd); end
      bus_read(3'd5, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_ifr: got %h want 00", rd); end
   endtask

   task automatic test_port();
      bus_write(3'd0, 8'hA5);
      n_checks++; if (port_out !== 8'hA5) begin n_fail++; $display("FAIL port_write: got %h want a5", port_out); end
      // Address presented; data must not appear before the clock edge.
      cs = 1'b1; we = 1'b0; addr = 3'd0;
      #1;
      n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL port_read_early: got %h want 00", dout); end
      @(negedge clk);
      cs = 1'b0;
      n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL port_read: got %h want a5", dout); end
      // Write without chip select is ignored; dout holds when not reading.
      we = 1'b1; addr = 3'd0; din = 8'hFF;
      repeat (2) @(negedge clk);
      we = 1'b0;
      n_checks++; if (port_out !== 8'hA5) begin n_fail++; $display("FAIL port_no_cs: got %h want a5", port_out); end
      n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL dout_hold: got %h want a5", dout); end
      bus_read(3'd7, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL read_addr7: got %h want 00", rd); end
   endtask

   task automatic test_edge();
      port_in = 8'h01;
      repeat (4) @(negedge clk);
      bus_write(3'd4, 8'hFC);
      bus_read(3'd4, rd);
      n_checks++; if (rd !== 8'h04) begin n_fail++; $display("FAIL ctrl_mask: got %h want 04", rd); end
      bus_read(3'd1, rd);
      n_checks++; if (rd !== 8'h01) begin n_fail++; $display("FAIL pin_high: got %h want 01", rd); end
      port_in = 8'h00;
      @(negedge clk);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_t1: got %b want 0", irq); end
      @(negedge clk);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_t2: got %b want 0", irq); end
      @(negedge clk);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL edge_t3: got %b want 1", irq); end
      bus_read(3'd1, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL pin_low: got %h want 00", rd); end
      bus_read(3'd5, rd);
      n_checks++; if (rd !== 8'h02) begin n_fail++; $display("FAIL edge_ifr: got %h want 02", rd); end
      bus_write(3'd5, 8'h01);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_other_bit: got %b want 1", irq); end
      bus_write(3'd5, 8'h02);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_clear: got %b want 0", irq); end
      bus_read(3'd5, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL edge_ifr_clr: got %h want 00", rd); end
   endtask

   task automatic test_oneshot();
      bus_write(3'd4, 8'h02);
      bus_write(3'd2, 8'h03);
      bus_read(3'd2, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL tlo_no_load: got %h want 00", rd); end
      bus_write(3'd3, 8'h00);
      // First edge after THI: pre-decrement counter is 3.
      bus_read(3'd2, rd);
      n_checks++; if (rd !== 8'h03) begin n_fail++; $display("FAIL oneshot_tlo: got %h want 03", rd); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_c1: got %b want 0", irq); end
      @(negedge clk);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_c2: got %b want 0", irq); end
      @(negedge clk);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_c3: got %b want 0", irq); end
      @(negedge clk);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_c4: got %b want 1", irq); end
      bus_read(3'd2, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL oneshot_tlo0: got %h want 00", rd); end
      bus_read(3'd3, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL oneshot_thi0: got %h want 00", rd); end
      bus_write(3'd5, 8'h01);
      repeat (10) @(negedge clk);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_stop: got %b want 0", irq); end
      bus_read(3'd2, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL oneshot_hold0: got %h want 00", rd); end
   endtask

   task automatic test_continuous();
      bus_write(3'd4, 8'h03);
      bus_write(3'd2, 8'h02);
      bus_write(3'd3, 8'h00);
      @(negedge clk);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL cont_c1: got %b want 0", irq); end
      @(negedge clk);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL cont_c2: got %b want 0", irq); end
      @(negedge clk);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL cont_c3: got %b want 1", irq); end
      bus_write(3'd5, 8'h01);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL cont_clear: got %b want 0", irq); end
      @(negedge clk);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL cont_c5: got %b want 0", irq); end
      @(negedge clk);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL cont_c6: got %b want 1", irq); end
      repeat (2) @(negedge clk);
      // Clear lands on the same edge as the next underflow.
      bus_write(3'd5, 8'h01);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL clear_vs_set: got %b want 1", irq); end
   endtask

   task automatic test_back_to_back();
      bus_write(3'd5, 8'h01);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL b2b_clear: got %b want 0", irq); end
      @(negedge clk);
      // THI write on the edge where the counter underflows.
      bus_write(3'd3, 8'h05);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL thi_vs_uflow_irq: got %b want 0", irq); end
      bus_read(3'd3, rd);
      n_checks++; if (rd !== 8'h05) begin n_fail++; $display("FAIL thi_vs_uflow_hi: got %h want 05", rd); end
      bus_read(3'd2, rd);
      n_checks++; if (rd !== 8'h01) begin n_fail++; $display("FAIL thi_vs_uflow_lo: got %h want 01", rd); end
      bus_read(3'd5, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL thi_vs_uflow_ifr: got %h want 00", rd); end
   endtask

   task automatic test_reset_mid();
      bus_read(3'd0, rd);
      bus_write(3'd3, 8'h00);
      repeat (3) @(negedge clk);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_pre_irq: got %b want 1", irq); end
      n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL mid_pre_dout: got %h want a5", dout); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq: got %b want 0", irq); end
      n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL mid_dout: got %h want 00", dout); end
      n_checks++; if (port_out !== 8'h00) begin n_fail++; $display("FAIL mid_port_out: got %h want 00", port_out); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      bus_read(3'd2, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mid_tlo: got %h want 00", rd); end
      bus_read(3'd3, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mid_thi: got %h want 00", rd); end
      bus_read(3'd5, rd);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mid_ifr: got %h want 00", rd); end
   endtask

   initial begin
      test_reset();
      test_port();
      test_edge();
      test_oneshot();
      test_continuous();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
